ysyx_23060180_lsu: RTL

YSYX_23060180_LSU -- requirements
Module: ysyx_23060180_lsu

---
 rtl/ysyx_23060180_lsu.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/ysyx_23060180_lsu.sv
// rtl/ysyx_23060180_lsu.sv - RV32I load/store unit: one outstanding access, lane steering and load extension
module ysyx_23060180_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_rd,
    output logic        resp_err,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t      state;
    logic        we_q;
    logic [2:0]  func3_q;
    logic [1:0]  addr_lo_q;
    logic [4:0]  rd_q;

    logic        acc_illegal;
    logic        acc_misaligned;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [31:0] load_shifted;
    logic [31:0] load_data;

    // Held low during reset so the producer never sees a handshake while the FSM is being cleared
    assign req_ready = (state == S_IDLE) && !rst;

    // Classify the incoming request: illegal encoding, or a halfword/word not on its natural boundary
    always_comb begin
        acc_illegal    = 1'b0;
        acc_misaligned = 1'b0;
        if (req_we) begin
            acc_illegal = (req_func3 > 3'b010);
        end else begin
            acc_illegal = !(req_func3 == 3'b000 || req_func3 == 3'b001 || req_func3 == 3'b010 ||
                            req_func3 == 3'b100 || req_func3 == 3'b101);
        end
        if (req_func3[1:0] == 2'b01) begin
            acc_misaligned = req_addr[0];
        end else if (req_func3[1:0] == 2'b10) begin
            acc_misaligned = (req_addr[1:0] != 2'b00);
        end
    end

    // Store data is replicated across all lanes; the strobe picks the lane(s) actually written
    always_comb begin
        st_wdata = req_wdata;
        st_wstrb = 4'b1111;
        case (req_func3[1:0])
            2'b00: begin
                st_wdata = {4{req_wdata[7:0]}};
                st_wstrb = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                st_wdata = {2{req_wdata[15:0]}};
                st_wstrb = 4'b0011 << req_addr[1:0];
            end
            default: begin
                st_wdata = req_wdata;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    // Bring the addressed byte/half down to bit 0, then sign- or zero-extend by access type
    assign load_shifted = bus_rdata >> {addr_lo_q, 3'b000};
    always_comb begin
        load_data = bus_rdata;
        case (func3_q)
            3'b000:  load_data = {{24{load_shifted[7]}}, load_shifted[7:0]};
            3'b001:  load_data = {{16{load_shifted[15]}}, load_shifted[15:0]};
            3'b100:  load_data = {24'd0, load_shifted[7:0]};
            3'b101:  load_data = {16'd0, load_shifted[15:0]};
            default: load_data = bus_rdata;
        endcase
    end

    // Transaction FSM; every bus and response output is a register written here
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            we_q          <= 1'b0;
            func3_q       <= 3'd0;
            addr_lo_q     <= 2'd0;
            rd_q          <= 5'd0;
            resp_valid    <= 1'b0;
            resp_rdata    <= 32'd0;
            resp_rd       <= 5'd0;
            resp_err      <= 1'b0;
            bus_req_valid <= 1'b0;
            bus_we        <= 1'b0;
            bus_addr      <= 32'd0;
            bus_wdata     <= 32'd0;
            bus_wstrb     <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        func3_q   <= req_func3;
                        addr_lo_q <= req_addr[1:0];
                        rd_q      <= req_rd;
                        if (acc_illegal || acc_misaligned) begin
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'd0;
                            resp_rd    <= 5'd0;
                        end else begin
                            state         <= S_REQ;
                            bus_req_valid <= 1'b1;
                            bus_we        <= req_we;
                            bus_addr      <= {req_addr[31:2], 2'b00};
                            bus_wdata     <= st_wdata;
                            bus_wstrb     <= req_we ? st_wstrb : 4'b0000;
                        end
                    end
                end
                S_REQ: begin
                    if (bus_req_ready) begin
                        bus_req_valid <= 1'b0;
                        state         <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus_rsp_valid) begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= we_q ? 32'd0 : load_data;
                        resp_rd    <= we_q ? 5'd0 : rd_q;
                    end
                end
                S_RESP: begin
                    state      <= S_IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'd0;
                    resp_rd    <= 5'd0;
                    bus_we     <= 1'b0;
                    bus_wstrb  <= 4'd0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
